// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Iteration-counter width, ceil(log2(N+1)), for the default N=8 and as a helper for any N.
  localparam int unsigned ITER_CNT_W = $clog2(8 + 1);

  function automatic int unsigned iter_cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring division iteration: shift in a dividend bit, trial-subtract, keep or restore.
module divider_step
  import divider_pkg::*;
#(
  parameter int unsigned M = 4
) (
  input  logic [M-1:0] rem_in,
  input  logic         bit_in,
  input  logic [M-1:0] divisor,
  output logic [M-1:0] rem_out,
  output logic         q_bit
);

  logic [M:0]   shifted;
  logic [M+1:0] diff;

  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = {1'b0, shifted} - {2'b00, divisor};
    q_bit   = ~diff[M+1];
    // On success the difference is below the divisor, so it fits in M bits.
    rem_out = q_bit ? diff[M-1:0] : shifted[M-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle, signed/unsigned with dbz/ovf flags.
module seq_divider
  import divider_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned M         = 4,
  parameter int unsigned SIGNED_EN = 1
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  input  logic         is_signed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         dbz,
  output logic         ovf,
  output logic         busy
);

  localparam int unsigned CW = iter_cnt_w(N);

  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic [N-1:0]  dq;
  logic [M-1:0]  rem;
  logic [M-1:0]  dvs;
  logic          q_neg, r_neg;
  logic [N-1:0]  q_res;
  logic [M-1:0]  r_res;
  logic          dbz_r, ovf_r;

  logic          accept, sgn, a_neg, b_neg, b_zero, ovf_det, last;
  logic [N-1:0]  a_mag;
  logic [M-1:0]  b_mag;
  logic [M-1:0]  rem_nxt;
  logic          q_bit;
  logic [N-1:0]  q_fin;

  always_comb begin
    in_ready = (state == ST_IDLE);
    accept   = in_valid & in_ready;
    sgn      = (SIGNED_EN != 0) && is_signed;
    a_neg    = sgn & dividend[N-1];
    b_neg    = sgn & divisor[M-1];
    a_mag    = a_neg ? -dividend : dividend;
    b_mag    = b_neg ? -divisor : divisor;
    b_zero   = (divisor == '0);
    ovf_det  = sgn && (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == '1);
    last     = (cnt == CW'(N - 1));
    q_fin    = {dq[N-2:0], q_bit};
  end

  divider_step #(.M(M)) u_step (
    .rem_in  (rem),
    .bit_in  (dq[N-1]),
    .divisor (dvs),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = b_zero ? ST_DONE : ST_CALC;
      ST_CALC: if (last) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // dq holds the magnitude of the dividend and shifts quotient bits in from the LSB.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt   <= '0;
      dq    <= '0;
      rem   <= '0;
      dvs   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      q_res <= '0;
      r_res <= '0;
      dbz_r <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cnt   <= '0;
            dq    <= a_mag;
            rem   <= '0;
            dvs   <= b_mag;
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
            if (b_zero) begin
              q_res <= '1;
              r_res <= '0;
              dbz_r <= 1'b1;
              ovf_r <= 1'b0;
            end else begin
              dbz_r <= 1'b0;
              ovf_r <= ovf_det;
            end
          end
        end
        ST_CALC: begin
          dq  <= q_fin;
          rem <= rem_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            q_res <= q_neg ? -q_fin : q_fin;
            r_res <= r_neg ? -rem_nxt : rem_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    out_valid = (state == ST_DONE);
    busy      = (state != ST_IDLE);
    quotient  = out_valid ? q_res : '0;
    remainder = out_valid ? r_res : '0;
    dbz       = out_valid ? dbz_r : 1'b0;
    ovf       = out_valid ? ovf_r : 1'b0;
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table plus scoreboard, with stall and abort sequences.
module tb_seq_divider;

  localparam int N = 8;
  localparam int M = 4;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         in_valid, in_ready;
  logic [N-1:0] dividend;
  logic [M-1:0] divisor;
  logic         is_signed;
  logic         out_valid, out_ready;
  logic [N-1:0] quotient;
  logic [M-1:0] remainder;
  logic         dbz, ovf, busy;

  seq_divider #(.N(N), .M(M), .SIGNED_EN(1)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [N-1:0] a;
    logic [M-1:0] b;
    logic         s;
    logic [N-1:0] q;
    logic [M-1:0] r;
    logic         dbz;
    logic         ovf;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int unsigned nvec = 0;
  int unsigned nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: integer division in SV truncates toward zero, % takes the dividend's sign.
  function automatic vec_t model(input logic [N-1:0] a, input logic [M-1:0] b, input logic s);
    vec_t v;
    int ia, ib, iq, ir;
    v.a = a; v.b = b; v.s = s;
    if (b == '0) begin
      v.q = '1; v.r = '0; v.dbz = 1'b1; v.ovf = 1'b0;
    end else begin
      if (s) begin
        ia = int'($signed(a));
        ib = int'($signed(b));
      end else begin
        ia = int'(a);
        ib = int'(b);
      end
      iq = ia / ib;
      ir = ia % ib;
      v.q   = N'(iq);
      v.r   = M'(ir);
      v.dbz = 1'b0;
      v.ovf = s && (ia == -(2 ** (N - 1))) && (ib == -1);
    end
    return v;
  endfunction

  task automatic drive(input vec_t v);
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge CLK);
    check("in_ready_idle", 32'(in_ready), 32'(1));
    dividend  = v.a;
    divisor   = v.b;
    is_signed = v.s;
    in_valid  = 1'b1;
    @(posedge CLK);
    sb.push_back(v);
    #1;
    in_valid  = 1'b0;
    dividend  = N'($urandom);
    divisor   = M'($urandom);
    is_signed = 1'($urandom);
  endtask

  task automatic do_op(input vec_t v, input int hold);
    int   lat;
    bit   got;
    vec_t e;
    logic [N-1:0] q0;
    logic [M-1:0] r0;
    drive(v);
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      lat++;
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    check("out_valid_seen", 32'(got), 32'(1));
    e = sb.pop_front();
    if (got) begin
      check("latency", 32'(lat), e.dbz ? 32'(1) : 32'(N + 1));
      check("quotient", 32'(quotient), 32'(e.q));
      check("remainder", 32'(remainder), 32'(e.r));
      check("dbz", 32'(dbz), 32'(e.dbz));
      check("ovf", 32'(ovf), 32'(e.ovf));
      check("busy_done", 32'(busy), 32'(1));
      check("in_ready_done", 32'(in_ready), 32'(0));
      q0 = quotient;
      r0 = remainder;
      for (int i = 0; i < hold; i++) begin
        @(negedge CLK);
        check("stall_valid", 32'(out_valid), 32'(1));
        check("stall_q", 32'(quotient), 32'(q0));
        check("stall_r", 32'(remainder), 32'(r0));
        check("stall_in_ready", 32'(in_ready), 32'(0));
      end
      out_ready = 1'b1;
      @(posedge CLK);
      #1;
      out_ready = 1'b0;
      check("in_ready_after", 32'(in_ready), 32'(1));
      check("out_valid_after", 32'(out_valid), 32'(0));
      check("q_zero_after", 32'(quotient), 32'(0));
      check("busy_after", 32'(busy), 32'(0));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bit   seen;

    RESET = 1'b1; out_ready = 1'b0;
    in_valid = 1'b1; dividend = 8'd200; divisor = 4'd7; is_signed = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    in_valid = 1'b0;
    RESET = 1'b0;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_quotient", 32'(quotient), 32'(0));
    check("rst_remainder", 32'(remainder), 32'(0));
    check("rst_dbz", 32'(dbz), 32'(0));
    check("rst_ovf", 32'(ovf), 32'(0));

    //              a      b     s     q      r     dbz   ovf
    vecs.push_back('{8'd200, 4'd7, 1'b0, 8'd28,  4'd4, 1'b0, 1'b0});
    vecs.push_back('{8'h9C,  4'd7, 1'b1, 8'hF2,  4'hE, 1'b0, 1'b0});
    vecs.push_back('{8'd55,  4'd0, 1'b0, 8'hFF,  4'd0, 1'b1, 1'b0});
    vecs.push_back('{8'h80,  4'hF, 1'b1, 8'h80,  4'd0, 1'b0, 1'b1});
    vecs.push_back('{8'd15,  4'd3, 1'b0, 8'd5,   4'd0, 1'b0, 1'b0});
    vecs.push_back('{8'd255, 4'hF, 1'b0, 8'd17,  4'd0, 1'b0, 1'b0});
    vecs.push_back('{8'h80,  4'hF, 1'b0, 8'd8,   4'd8, 1'b0, 1'b0});
    vecs.push_back('{8'd100, 4'h9, 1'b1, 8'hF2,  4'd2, 1'b0, 1'b0});
    vecs.push_back('{8'h9C,  4'h9, 1'b1, 8'h0E,  4'hE, 1'b0, 1'b0});
    vecs.push_back('{8'd7,   4'd9, 1'b0, 8'd0,   4'd7, 1'b0, 1'b0});
    vecs.push_back('{8'h85,  4'd0, 1'b1, 8'hFF,  4'd0, 1'b1, 1'b0});
    vecs.push_back('{8'hFF,  4'h8, 1'b1, 8'd0,   4'hF, 1'b0, 1'b0});
    vecs.push_back('{8'h7F,  4'd1, 1'b1, 8'h7F,  4'd0, 1'b0, 1'b0});

    for (int i = 0; i < vecs.size(); i++) do_op(vecs[i], 0);

    for (int i = 0; i < 12; i++) begin
      v = model(N'($urandom), M'($urandom), 1'($urandom));
      do_op(v, 0);
    end

    // Result held while the consumer stalls.
    v = '{8'd200, 4'd7, 1'b0, 8'd28, 4'd4, 1'b0, 1'b0};
    do_op(v, 5);

    // Reset in the 4th CALC cycle aborts the operation.
    @(negedge CLK);
    drive('{8'd200, 4'd7, 1'b0, 8'd28, 4'd4, 1'b0, 1'b0});
    @(negedge CLK);
    repeat (3) @(negedge CLK);
    check("calc_busy", 32'(busy), 32'(1));
    out_ready = 1'b1;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    out_ready = 1'b0;
    void'(sb.pop_front());
    check("abort_in_ready", 32'(in_ready), 32'(1));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_out_valid", 32'(out_valid), 32'(0));
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      seen |= out_valid;
    end
    check("abort_no_result", 32'(seen), 32'(0));
    do_op('{8'd15, 4'd3, 1'b0, 8'd5, 4'd0, 1'b0, 1'b0}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter N, default 8, dividend and quotient width (N >= 2).
REQ-002 SHALL have parameter M, default 4, divisor and remainder width (2 <= M <= N).
REQ-003 SHALL have parameter SIGNED_EN, default 1; when 0, the signed mode is ignored and operands are treated as unsigned.
REQ-004 SHALL have port CLK  input  1  clock; all state changes on the rising edge.
REQ-005 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports in_valid  input  1 and in_ready  output  1  operand handshake.
REQ-007 SHALL have ports dividend  input  N and divisor  input  M  operands, sampled on accept.
REQ-008 SHALL have port is_signed  input  1  two's-complement mode for this operation, sampled on accept.
REQ-009 SHALL have ports out_valid  output  1 and out_ready  input  1  result handshake.
REQ-010 SHALL have ports quotient  output  N and remainder  output  M  result.
REQ-011 SHALL have ports dbz  output  1 and ovf  output  1  divide-by-zero and signed-overflow flags.
REQ-012 SHALL have port busy  output  1, high whenever the state is not IDLE.

Function
REQ-013 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-014 SHALL assert in_ready only in IDLE; accept when in_valid and in_ready are both high on a rising edge.
REQ-015 SHALL, on accept with divisor nonzero, go to CALC and run exactly N restoring iterations, one quotient bit per cycle, MSB first.
REQ-016 SHALL use an (M+1)-bit partial remainder each iteration: shift in the next dividend bit, compare against the divisor, subtract if greater or equal, and set the quotient bit.
REQ-017 SHALL assert out_valid in cycle k+N+1 for an operation accepted in cycle k, then enter DONE.
REQ-018 SHALL, on accept with divisor zero, skip CALC and enter DONE with out_valid in cycle k+1, quotient all ones, remainder 0, dbz=1 and ovf=0.
REQ-019 SHALL, in signed mode, divide the operand magnitudes, truncate the quotient toward zero, and give the remainder the sign of the dividend (zero remainder stays zero).
REQ-020 SHALL, in signed mode with dividend = -2^(N-1) and divisor = -1, return quotient -2^(N-1), remainder 0 and ovf=1, with the normal latency.
REQ-021 SHALL hold quotient, remainder, dbz and ovf stable and out_valid high in DONE until out_ready is high on an edge, then return to IDLE.
REQ-022 SHALL NOT accept new operands in the cycle a result is consumed; in_ready rises in the following cycle (IDLE).
REQ-023 SHALL drive quotient, remainder, dbz and ovf to 0 whenever out_valid is low.
REQ-024 SHALL ignore changes on dividend, divisor and is_signed after accept.

Reset
REQ-025 SHALL, with RESET high on an edge, enter IDLE and set out_valid=0, busy=0, quotient=0, remainder=0, dbz=0 and ovf=0; in_ready=1 after that edge.
REQ-026 SHALL abort any operation in CALC or DONE on reset, with no result produced.
REQ-027 SHALL give RESET priority over in_valid and out_ready on the same edge.

Structure
REQ-028 SHALL place the FSM state encoding and a localparam for the iteration-counter width, ceil(log2(N+1)), in the shared package divider_pkg.
REQ-029 SHALL use one combinational sub-module, divider_step, to perform a single restoring iteration.
REQ-030 SHALL use a single iteration counter, one shared subtractor and no multiplier.

Verification
REQ-031 SHALL cover: N=8, M=4, unsigned 200/7 -> quotient 28, remainder 4, out_valid 9 cycles after accept.
REQ-032 SHALL cover: signed -100/7 -> quotient 0xF2 (-14), remainder 4'hE (-2), dbz=0, ovf=0.
REQ-033 SHALL cover: 55/0 -> quotient 0xFF, remainder 0, dbz=1, out_valid 1 cycle after accept.
REQ-034 SHALL cover: signed 0x80/4'hF -> quotient 0x80, remainder 0, ovf=1.
REQ-035 SHALL cover: out_ready held low 5 cycles in DONE -> outputs stable, in_ready low; then out_ready high -> IDLE and in_ready high the next cycle.
REQ-036 SHALL cover: RESET pulsed in the 4th CALC cycle -> IDLE, out_valid never asserts; then 15/3 -> quotient 5, remainder 0.
